// File: rtl/adder_arbiter_if.sv
// adder_arbiter_if: request/response bus between four requesters and the shared adder
interface adder_arbiter_if #(parameter int W = 4);
   logic           ena;
   logic [3:0]     req_valid;
   logic [4*W-1:0] req_a;
   logic [4*W-1:0] req_b;
   logic [3:0]     req_ready;
   logic           rsp_valid;
   logic           rsp_ready;
   logic [1:0]     rsp_id;
   logic [W:0]     rsp_sum;
   logic           busy;
   modport master (
      output ena, req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_sum, busy
   );
   modport slave (
      input  ena, req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_sum, busy
   );
endinterface

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter granting one of four requesters access to a registered adder
module adder_arbiter #(
   parameter int W = 4
) (
   input logic            clk,
   input logic            rst,
   adder_arbiter_if.slave s
);
   typedef enum logic [1:0] {IDLE, ADD, RESP} state_t;
   state_t         state_q, state_d;
   logic [1:0]     last_q, last_d;
   logic [1:0]     id_q, id_d;
   logic [1:0]     rid_q, rid_d;
   logic [W-1:0]   a_q, a_d;
   logic [W-1:0]   b_q, b_d;
   logic [W:0]     sum_q, sum_d;
   logic [1:0]     win;
   logic [1:0]     idx;
   logic [3:0]     req_ready;
   logic           grant;
   // round-robin pick: scan farthest to nearest so the requester just after last_q wins
   always_comb begin
      win = last_q;
      idx = last_q;
      for (int k = 3; k >= 0; k--) begin
         idx = last_q + 2'(k + 1);
         if (s.req_valid[idx]) win = idx;
      end
   end
   // next-state and grant logic; reset suppresses grants combinationally
   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      id_d      = id_q;
      rid_d     = rid_q;
      a_d       = a_q;
      b_d       = b_q;
      sum_d     = sum_q;
      req_ready = '0;
      grant     = (state_q == IDLE) && s.ena && (|s.req_valid) && !rst;
      case (state_q)
         IDLE: begin
            if (grant) begin
               req_ready[win] = 1'b1;
               a_d     = s.req_a[win*W +: W];
               b_d     = s.req_b[win*W +: W];
               id_d    = win;
               last_d  = win;
               state_d = ADD;
            end
         end
         ADD: begin
            sum_d   = {1'b0, a_q} + {1'b0, b_q};
            rid_d   = id_q;
            state_d = RESP;
         end
         RESP:    state_d = s.rsp_ready ? IDLE : RESP;
         default: state_d = IDLE;
      endcase
   end
   // state registers; last_q resets to 3 so requester 0 has first priority
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         last_q  <= 2'd3;
         id_q    <= '0;
         rid_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         id_q    <= id_d;
         rid_q   <= rid_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
      end
   end
   assign s.req_ready = req_ready;
   assign s.rsp_valid = (state_q == RESP);
   assign s.rsp_sum   = sum_q;
   assign s.rsp_id    = rid_q;
   assign s.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: vector table plus corner sequences with a response scoreboard
module tb_adder_arbiter;
   localparam int W = 4;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errs = 0;
   int   checks = 0;
   adder_arbiter_if #(.W(W)) bus ();
   adder_arbiter #(.W(W)) dut (.clk(clk), .rst(rst), .s(bus));
   always #5 clk = ~clk;
   typedef struct {
      logic [3:0]  valid;
      logic [15:0] a;
      logic [15:0] b;
      logic [1:0]  id;
      logic [4:0]  sum;
      int          bp;
   } vec_t;
   typedef struct {
      logic [1:0] id;
      logic [4:0] sum;
   } exp_t;
   exp_t sb[$];
   vec_t vecs[8];
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errs++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, want, $time);
      end
   endtask
   task automatic grant(input logic [3:0] v, input logic [15:0] a, input logic [15:0] b,
                        input logic [1:0] id, input logic [4:0] sum);
      @(posedge clk); #1;
      bus.req_valid = v;
      bus.req_a     = a;
      bus.req_b     = b;
      bus.ena       = 1'b1;
      bus.rsp_ready = 1'b0;
      @(negedge clk);
      chk("grant", 32'(bus.req_ready), 32'(4'b0001 << id));
      chk("busy_idle", 32'(bus.busy), 0);
      sb.push_back('{id, sum});
      @(posedge clk); #1;
      bus.req_valid = '0;
      bus.req_a     = ~a;
      bus.req_b     = ~b;
   endtask
   task automatic respond(input int bp);
      int n = 0;
      exp_t e;
      logic [4:0] s;
      logic [1:0] i;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.rsp_valid && n < 10);
      chk("latency", n, 2);
      if (sb.size() == 0) begin
         errs++;
         $display("FAIL scoreboard: got response, want none pending");
      end else begin
         e = sb.pop_front();
         chk("rsp_id", 32'(bus.rsp_id), 32'(e.id));
         chk("rsp_sum", 32'(bus.rsp_sum), 32'(e.sum));
      end
      s = bus.rsp_sum;
      i = bus.rsp_id;
      bus.req_valid = 4'hF;
      for (int k = 0; k < bp; k++) begin
         @(negedge clk);
         chk("bp_valid", 32'(bus.rsp_valid), 1);
         chk("bp_sum", 32'(bus.rsp_sum), 32'(s));
         chk("bp_id", 32'(bus.rsp_id), 32'(i));
         chk("bp_grant", 32'(bus.req_ready), 0);
      end
      bus.rsp_ready = 1'b1;
      #1;
      chk("accept_grant", 32'(bus.req_ready), 0);
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
      bus.req_valid = '0;
      @(negedge clk);
      chk("idle_busy", 32'(bus.busy), 0);
      chk("idle_valid", 32'(bus.rsp_valid), 0);
      chk("hold_sum", 32'(bus.rsp_sum), 32'(s));
      chk("hold_id", 32'(bus.rsp_id), 32'(i));
   endtask
   task automatic do_reset();
      @(posedge clk); #1;
      rst           = 1'b1;
      bus.ena       = 1'b1;
      bus.req_valid = 4'hF;
      bus.rsp_ready = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_ready", 32'(bus.req_ready), 0);
      chk("rst_valid", 32'(bus.rsp_valid), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_sum", 32'(bus.rsp_sum), 0);
      chk("rst_id", 32'(bus.rsp_id), 0);
      @(posedge clk); #1;
      rst           = 1'b0;
      bus.req_valid = '0;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   initial begin
      vecs = '{
         '{4'b0001, 16'h0003, 16'h0005, 2'd0, 5'd8,  0},
         '{4'b0100, 16'h0F00, 16'h0F00, 2'd2, 5'd30, 5},
         '{4'b1111, 16'h1234, 16'h5678, 2'd3, 5'd6,  0},
         '{4'b1111, 16'h1234, 16'h5678, 2'd0, 5'd12, 1},
         '{4'b1010, 16'hFEDC, 16'h9876, 2'd1, 5'd20, 0},
         '{4'b1010, 16'hFEDC, 16'h9876, 2'd3, 5'd24, 2},
         '{4'b0110, 16'h0000, 16'h0000, 2'd1, 5'd0,  0},
         '{4'b0001, 16'h000F, 16'h0001, 2'd0, 5'd16, 0}
      };
      bus.ena       = 1'b0;
      bus.req_valid = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.rsp_ready = 1'b0;
      do_reset();
      foreach (vecs[n]) begin
         grant(vecs[n].valid, vecs[n].a, vecs[n].b, vecs[n].id, vecs[n].sum);
         respond(vecs[n].bp);
      end
      @(posedge clk); #1;
      bus.ena       = 1'b0;
      bus.req_valid = 4'b0010;
      bus.req_a     = 16'h00A0;
      bus.req_b     = 16'h0050;
      repeat (3) begin
         @(negedge clk);
         chk("ena_block", 32'(bus.req_ready), 0);
         chk("ena_busy", 32'(bus.busy), 0);
      end
      @(posedge clk); #1;
      bus.ena = 1'b1;
      @(negedge clk);
      chk("ena_grant", 32'(bus.req_ready), 32'(4'b0010));
      sb.push_back('{2'd1, 5'd15});
      @(posedge clk); #1;
      bus.ena       = 1'b0;
      bus.req_valid = '0;
      respond(0);
      @(posedge clk); #1;
      bus.ena       = 1'b1;
      bus.req_valid = 4'b0001;
      bus.req_a     = 16'h0007;
      bus.req_b     = 16'h0009;
      @(negedge clk);
      chk("radd_grant", 32'(bus.req_ready), 32'(4'b0001));
      @(posedge clk); #1;
      rst           = 1'b1;
      bus.req_valid = '0;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (6) begin
         @(negedge clk);
         chk("radd_valid", 32'(bus.rsp_valid), 0);
         chk("radd_sum", 32'(bus.rsp_sum), 0);
         chk("radd_busy", 32'(bus.busy), 0);
      end
      do_reset();
      bus.ena       = 1'b1;
      bus.rsp_ready = 1'b1;
      bus.req_valid = 4'hF;
      for (int n = 0; n < 15; n++) begin
         @(negedge clk);
         chk($sformatf("rr_%0d", n), 32'(bus.req_ready),
             (n % 3 == 0) ? 32'(1 << ((n / 3) % 4)) : 0);
      end
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
